// File: rtl/arbiter2_wb8_pkg.sv
// Shared definitions for the two-master 8-bit Wishbone arbiter.
// State encoding, default watchdog limit and the state-to-grant decode.
package arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  function automatic logic [1:0] grant_of(input logic [1:0] st);
    case (st)
      ST_OWN0: return 2'b01;
      ST_OWN1: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/arbiter2_wb8_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the shared slave side.
// The arbiter uses the slave modport; the master modport drives it.
interface arbiter2_wb8_if;
  logic        M0_CYC_I, M0_STB_I, M0_WE_I;
  logic [31:0] M0_ADR_I;
  logic [7:0]  M0_DAT_I;
  logic [7:0]  M0_DAT_O;
  logic        M0_ACK_O, M0_ERR_O;

  logic        M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [31:0] M1_ADR_I;
  logic [7:0]  M1_DAT_I;
  logic [7:0]  M1_DAT_O;
  logic        M1_ACK_O, M1_ERR_O;

  logic        S_CYC_O, S_STB_O, S_WE_O;
  logic [31:0] S_ADR_O;
  logic [7:0]  S_DAT_O;
  logic [7:0]  S_DAT_I;
  logic        S_ACK_I;

  modport slave (
    input  M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
    input  M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
    input  S_DAT_I, S_ACK_I,
    output M0_DAT_O, M0_ACK_O, M0_ERR_O,
    output M1_DAT_O, M1_ACK_O, M1_ERR_O,
    output S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O
  );

  modport master (
    output M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
    output M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
    output S_DAT_I, S_ACK_I,
    input  M0_DAT_O, M0_ACK_O, M0_ERR_O,
    input  M1_DAT_O, M1_ACK_O, M1_ERR_O,
    input  S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O
  );
endinterface

// File: rtl/arbiter2_wb8_watchdog.sv
// Slave-stall watchdog: counts strobed cycles without ack and pulses expire
// in the cycle the count equals TIMEOUT, unless an ack arrives in that cycle.
module wb_watchdog
  import arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic stb,
  input  logic ack,
  input  logic clear,
  output logic expire
);

  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT);

  logic [7:0] cnt;

  assign expire = stb && !ack && (cnt == TERM_CNT);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clear || ack || !stb || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/arbiter2_wb8.sv
// Two-master round-robin Wishbone arbiter with an 8-bit data path and a
// stall watchdog that returns a bus error to the owning master.
//
// state | meaning
// IDLE  | no owner, shared bus driven to 0
// OWN0  | master 0 owns the shared bus
// OWN1  | master 1 owns the shared bus
module arbiter2_wb8
  import arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  arbiter2_wb8_if.slave bus,
  output logic [1:0]    O_grant
);

  logic [1:0] state, state_nxt;
  logic       rr_last;
  logic       rr_vld;
  logic       own0, own1;
  logic       stb_raw;
  logic       expire;

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

  // Until the first grant after reset, contention resolves to master 0.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.M0_CYC_I && bus.M1_CYC_I) state_nxt = (rr_vld && !rr_last) ? ST_OWN1 : ST_OWN0;
        else if (bus.M0_CYC_I)            state_nxt = ST_OWN0;
        else if (bus.M1_CYC_I)            state_nxt = ST_OWN1;
      end
      ST_OWN0: if (!bus.M0_CYC_I) state_nxt = bus.M1_CYC_I ? ST_OWN1 : ST_IDLE;
      ST_OWN1: if (!bus.M1_CYC_I) state_nxt = bus.M0_CYC_I ? ST_OWN0 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state   <= ST_IDLE;
      O_grant <= 2'b00;
      rr_last <= 1'b0;
      rr_vld  <= 1'b0;
    end else begin
      state   <= state_nxt;
      O_grant <= grant_of(state_nxt);
      if (state_nxt != state && state_nxt != ST_IDLE) begin
        rr_last <= (state_nxt == ST_OWN1);
        rr_vld  <= 1'b1;
      end
    end
  end

  assign stb_raw = (own0 && bus.M0_STB_I) || (own1 && bus.M1_STB_I);

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_sys (CLK_I),
    .rst_b   (RST_I),
    .stb     (stb_raw),
    .ack     (bus.S_ACK_I),
    .clear   (state_nxt != state),
    .expire  (expire)
  );

  always_comb begin
    bus.S_CYC_O = 1'b0;
    bus.S_STB_O = 1'b0;
    bus.S_WE_O  = 1'b0;
    bus.S_ADR_O = '0;
    bus.S_DAT_O = '0;
    if (own0) begin
      bus.S_CYC_O = bus.M0_CYC_I;
      bus.S_STB_O = bus.M0_STB_I && !expire;
      bus.S_WE_O  = bus.M0_WE_I;
      bus.S_ADR_O = bus.M0_ADR_I;
      bus.S_DAT_O = bus.M0_DAT_I;
    end else if (own1) begin
      bus.S_CYC_O = bus.M1_CYC_I;
      bus.S_STB_O = bus.M1_STB_I && !expire;
      bus.S_WE_O  = bus.M1_WE_I;
      bus.S_ADR_O = bus.M1_ADR_I;
      bus.S_DAT_O = bus.M1_DAT_I;
    end
  end

  assign bus.M0_ACK_O = own0 && bus.S_ACK_I;
  assign bus.M1_ACK_O = own1 && bus.S_ACK_I;
  assign bus.M0_ERR_O = own0 && expire;
  assign bus.M1_ERR_O = own1 && expire;
  assign bus.M0_DAT_O = own0 ? bus.S_DAT_I : 8'h00;
  assign bus.M1_DAT_O = own1 ? bus.S_DAT_I : 8'h00;

endmodule

// File: tb/tb_arbiter2_wb8.sv
// Directed testbench for arbiter2_wb8 built with a 4-cycle watchdog limit.
module tb_arbiter2_wb8;
  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b0;
  logic [1:0] O_grant;
  int         n_checks = 0;
  int         n_pass = 0;

  arbiter2_wb8_if bus ();

  arbiter2_wb8 #(.TIMEOUT(4)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .bus     (bus),
    .O_grant (O_grant)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #2;
  endtask

  task automatic clear_inputs();
    bus.M0_CYC_I = 0; bus.M0_STB_I = 0; bus.M0_WE_I = 0; bus.M0_ADR_I = '0; bus.M0_DAT_I = '0;
    bus.M1_CYC_I = 0; bus.M1_STB_I = 0; bus.M1_WE_I = 0; bus.M1_ADR_I = '0; bus.M1_DAT_I = '0;
    bus.S_ACK_I = 0; bus.S_DAT_I = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST_I = 1'b0;
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1; bus.M0_WE_I = 1; bus.M0_ADR_I = 32'hDEAD_BEEF; bus.M0_DAT_I = 8'h77;
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'hC3;
    tick();
    n_checks++; if (O_grant !== 2'b00) $display("FAIL rst_grant act=%b exp=00", O_grant); else n_pass++;
    n_checks++; if (bus.S_CYC_O !== 1'b0 || bus.S_STB_O !== 1'b0 || bus.S_WE_O !== 1'b0) $display("FAIL rst_sctl act=%b%b%b exp=000", bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O); else n_pass++;
    n_checks++; if (bus.S_ADR_O !== 32'h0 || bus.S_DAT_O !== 8'h0) $display("FAIL rst_sbus act=%h/%h exp=0/0", bus.S_ADR_O, bus.S_DAT_O); else n_pass++;
    n_checks++; if ({bus.M0_ACK_O, bus.M0_ERR_O, bus.M1_ACK_O, bus.M1_ERR_O} !== 4'b0) $display("FAIL rst_ackerr act=%b%b%b%b exp=0000", bus.M0_ACK_O, bus.M0_ERR_O, bus.M1_ACK_O, bus.M1_ERR_O); else n_pass++;
    n_checks++; if (bus.M0_DAT_O !== 8'h00 || bus.M1_DAT_O !== 8'h00) $display("FAIL rst_mdat act=%h/%h exp=00/00", bus.M0_DAT_O, bus.M1_DAT_O); else n_pass++;
    clear_inputs();
    @(negedge CLK_I);
    RST_I = 1'b1;
  endtask

  task automatic test_single_read();
    tick();
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1; bus.M0_WE_I = 0; bus.M0_ADR_I = 32'hFFFF_F000;
    #1;
    n_checks++; if (O_grant !== 2'b00 || bus.S_CYC_O !== 1'b0) $display("FAIL rd_lat act=%b/%b exp=00/0", O_grant, bus.S_CYC_O); else n_pass++;
    tick();
    n_checks++; if (O_grant !== 2'b01) $display("FAIL rd_grant act=%b exp=01", O_grant); else n_pass++;
    n_checks++; if (bus.S_CYC_O !== 1'b1 || bus.S_STB_O !== 1'b1 || bus.S_WE_O !== 1'b0) $display("FAIL rd_sctl act=%b%b%b exp=110", bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O); else n_pass++;
    n_checks++; if (bus.S_ADR_O !== 32'hFFFF_F000) $display("FAIL rd_adr act=%h exp=fffff000", bus.S_ADR_O); else n_pass++;
    tick();
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'hA5;
    #1;
    n_checks++; if (bus.M0_ACK_O !== 1'b1 || bus.M0_DAT_O !== 8'hA5) $display("FAIL rd_ack act=%b/%h exp=1/a5", bus.M0_ACK_O, bus.M0_DAT_O); else n_pass++;
    n_checks++; if (bus.M1_ACK_O !== 1'b0 || bus.M1_DAT_O !== 8'h00 || bus.M0_ERR_O !== 1'b0) $display("FAIL rd_other act=%b/%h/%b exp=0/00/0", bus.M1_ACK_O, bus.M1_DAT_O, bus.M0_ERR_O); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (O_grant !== 2'b01 || bus.S_CYC_O !== 1'b0) $display("FAIL rd_drop act=%b/%b exp=01/0", O_grant, bus.S_CYC_O); else n_pass++;
    tick();
    n_checks++; if (O_grant !== 2'b00) $display("FAIL rd_idle act=%b exp=00", O_grant); else n_pass++;
  endtask

  task automatic test_contention();
    apply_reset();
    tick();
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1; bus.M0_ADR_I = 32'h0000_00A0;
    bus.M1_CYC_I = 1; bus.M1_STB_I = 1; bus.M1_ADR_I = 32'h0000_00B0;
    tick();
    n_checks++; if (O_grant !== 2'b01 || bus.S_ADR_O !== 32'hA0) $display("FAIL ct_first act=%b/%h exp=01/a0", O_grant, bus.S_ADR_O); else n_pass++;
    bus.M0_CYC_I = 0; bus.M0_STB_I = 0;
    tick();
    n_checks++; if (O_grant !== 2'b10 || bus.S_ADR_O !== 32'hB0 || bus.S_CYC_O !== 1'b1) $display("FAIL ct_handover act=%b/%h/%b exp=10/b0/1", O_grant, bus.S_ADR_O, bus.S_CYC_O); else n_pass++;
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'h11;
    #1;
    n_checks++; if (bus.M1_ACK_O !== 1'b1 || bus.M0_ACK_O !== 1'b0 || bus.M1_DAT_O !== 8'h11 || bus.M0_DAT_O !== 8'h00) $display("FAIL ct_late_ack act=%b%b/%h/%h exp=10/11/00", bus.M1_ACK_O, bus.M0_ACK_O, bus.M1_DAT_O, bus.M0_DAT_O); else n_pass++;
    bus.S_ACK_I = 0;
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1;
    tick();
    n_checks++; if (O_grant !== 2'b10) $display("FAIL ct_hold act=%b exp=10", O_grant); else n_pass++;
    bus.M1_CYC_I = 0; bus.M1_STB_I = 0;
    tick();
    n_checks++; if (O_grant !== 2'b01 || bus.S_ADR_O !== 32'hA0) $display("FAIL ct_back act=%b/%h exp=01/a0", O_grant, bus.S_ADR_O); else n_pass++;
    clear_inputs();
    tick();
    n_checks++; if (O_grant !== 2'b00) $display("FAIL ct_idle act=%b exp=00", O_grant); else n_pass++;
  endtask

  task automatic test_idle_rr();
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1;
    bus.M1_CYC_I = 1; bus.M1_STB_I = 1;
    tick();
    n_checks++; if (O_grant !== 2'b10) $display("FAIL rr_m1 act=%b exp=10", O_grant); else n_pass++;
    clear_inputs();
    tick();
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1;
    bus.M1_CYC_I = 1; bus.M1_STB_I = 1;
    tick();
    n_checks++; if (O_grant !== 2'b01) $display("FAIL rr_m0 act=%b exp=01", O_grant); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    bus.M1_CYC_I = 1; bus.M1_STB_I = 1; bus.M1_WE_I = 1;
    bus.M1_ADR_I = 32'hFFFF_FF00; bus.M1_DAT_I = 8'h3C;
    bus.M0_ADR_I = 32'h1111_1111; bus.M0_DAT_I = 8'hEE;
    tick();
    n_checks++; if (O_grant !== 2'b10) $display("FAIL wr_grant act=%b exp=10", O_grant); else n_pass++;
    n_checks++; if (bus.S_WE_O !== 1'b1 || bus.S_DAT_O !== 8'h3C) $display("FAIL wr_data act=%b/%h exp=1/3c", bus.S_WE_O, bus.S_DAT_O); else n_pass++;
    n_checks++; if (bus.S_ADR_O !== 32'hFFFF_FF00) $display("FAIL wr_adr act=%h exp=ffffff00", bus.S_ADR_O); else n_pass++;
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'h77;
    #1;
    n_checks++; if (bus.M1_ACK_O !== 1'b1 || bus.M0_ACK_O !== 1'b0 || bus.M0_DAT_O !== 8'h00) $display("FAIL wr_ack act=%b/%b/%h exp=1/0/00", bus.M1_ACK_O, bus.M0_ACK_O, bus.M0_DAT_O); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1; bus.M0_ADR_I = 32'h0000_0040;
    tick();
    n_checks++; if (bus.S_STB_O !== 1'b1 || bus.M0_ERR_O !== 1'b0) $display("FAIL to_start act=%b/%b exp=1/0", bus.S_STB_O, bus.M0_ERR_O); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.S_STB_O !== 1'b1 || bus.M0_ERR_O !== 1'b0) $display("FAIL to_stall%0d act=%b/%b exp=1/0", i, bus.S_STB_O, bus.M0_ERR_O); else n_pass++;
    end
    tick();
    n_checks++; if (bus.M0_ERR_O !== 1'b1 || bus.S_STB_O !== 1'b0) $display("FAIL to_err act=%b/%b exp=1/0", bus.M0_ERR_O, bus.S_STB_O); else n_pass++;
    n_checks++; if (O_grant !== 2'b01 || bus.S_CYC_O !== 1'b1 || bus.M1_ERR_O !== 1'b0) $display("FAIL to_keep act=%b/%b/%b exp=01/1/0", O_grant, bus.S_CYC_O, bus.M1_ERR_O); else n_pass++;
    tick();
    n_checks++; if (bus.M0_ERR_O !== 1'b0 || bus.S_STB_O !== 1'b1) $display("FAIL to_pulse act=%b/%b exp=0/1", bus.M0_ERR_O, bus.S_STB_O); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.M0_ERR_O !== 1'b0) $display("FAIL to_restall%0d act=%b exp=0", i, bus.M0_ERR_O); else n_pass++;
    end
    tick();
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'h5C;
    #1;
    n_checks++; if (bus.M0_ACK_O !== 1'b1 || bus.M0_ERR_O !== 1'b0 || bus.S_STB_O !== 1'b1) $display("FAIL to_ackwin act=%b/%b/%b exp=1/0/1", bus.M0_ACK_O, bus.M0_ERR_O, bus.S_STB_O); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.M1_CYC_I = 1; bus.M1_STB_I = 1; bus.M1_WE_I = 1;
    bus.M1_ADR_I = 32'h1234_5678; bus.M1_DAT_I = 8'h99;
    tick();
    n_checks++; if (O_grant !== 2'b10) $display("FAIL rm_grant act=%b exp=10", O_grant); else n_pass++;
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'hEE;
    #1;
    RST_I = 1'b0;
    #1;
    n_checks++; if (O_grant !== 2'b00) $display("FAIL rm_grant0 act=%b exp=00", O_grant); else n_pass++;
    n_checks++; if (bus.S_CYC_O !== 1'b0 || bus.S_STB_O !== 1'b0 || bus.S_WE_O !== 1'b0 || bus.S_ADR_O !== 32'h0 || bus.S_DAT_O !== 8'h0) $display("FAIL rm_sbus act=%b%b%b/%h/%h exp=000/0/0", bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O, bus.S_ADR_O, bus.S_DAT_O); else n_pass++;
    n_checks++; if (bus.M1_ACK_O !== 1'b0 || bus.M1_ERR_O !== 1'b0 || bus.M1_DAT_O !== 8'h00) $display("FAIL rm_m1 act=%b/%b/%h exp=0/0/00", bus.M1_ACK_O, bus.M1_ERR_O, bus.M1_DAT_O); else n_pass++;
    clear_inputs();
    @(negedge CLK_I);
    RST_I = 1'b1;
    tick();
    bus.M0_CYC_I = 1; bus.M0_STB_I = 1;
    tick();
    n_checks++; if (O_grant !== 2'b01) $display("FAIL rm_regrant act=%b exp=01", O_grant); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_idle_ack();
    tick();
    bus.S_ACK_I = 1; bus.S_DAT_I = 8'h5A;
    #1;
    n_checks++; if (bus.M0_ACK_O !== 1'b0 || bus.M1_ACK_O !== 1'b0) $display("FAIL ia_ack act=%b/%b exp=0/0", bus.M0_ACK_O, bus.M1_ACK_O); else n_pass++;
    n_checks++; if (bus.M0_DAT_O !== 8'h00 || bus.M1_DAT_O !== 8'h00) $display("FAIL ia_dat act=%h/%h exp=00/00", bus.M0_DAT_O, bus.M1_DAT_O); else n_pass++;
    tick();
    n_checks++; if (O_grant !== 2'b00) $display("FAIL ia_grant act=%b exp=00", O_grant); else n_pass++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_idle_rr();
    test_write();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/arbiter2_wb8.md
ARBITER2_WB8 -- requirements
Module: arbiter2_wb8

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: slave-stall cycles before bus error (legal range 1..255).
REQ-002 CLK_I  in  1  system clock, all state on rising edge.
REQ-003 RST_I  in  1  reset, asynchronous, active-low.
REQ-004 Mn_CYC_I, Mn_STB_I, Mn_WE_I  in  1 each  Wishbone master n controls (n = 0, 1).
REQ-005 Mn_ADR_I  in  32  master n address; Mn_DAT_I  in  8  master n write data.
REQ-006 Mn_DAT_O  out  8  read data to master n; Mn_ACK_O  out  1  ack; Mn_ERR_O  out  1  timeout error.
REQ-007 S_CYC_O, S_STB_O, S_WE_O  out  1 each  shared-bus controls toward address decoder.
REQ-008 S_ADR_O  out  32; S_DAT_O  out  8  shared-bus address/write data.
REQ-009 S_DAT_I  in  8; S_ACK_I  in  1  shared-bus read data and ack.
REQ-010 O_grant  out  2  one-hot current owner (bit n = master n), 00 when idle.

Function
REQ-011 State machine SHALL have states IDLE, OWN0, OWN1; O_grant SHALL be a registered decode of state.
REQ-012 IDLE: M0_CYC_I only -> OWN0; M1_CYC_I only -> OWN1; both -> master not granted last (round-robin bit, reset value selects master 0 first).
REQ-013 OWNn: stay while Mn_CYC_I=1; when Mn_CYC_I=0 -> OWN(other) if other CYC=1 that cycle, else IDLE (no idle gap on handover).
REQ-014 Round-robin bit SHALL update to n on every entry into OWNn.
REQ-015 Grant latency: first cycle of CYC in IDLE -> S_CYC_O/S_STB_O asserted next cycle.
REQ-016 In OWNn, S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O SHALL be combinational copies of master n signals; in IDLE all SHALL be 0.
REQ-017 Mn_ACK_O = S_ACK_I and owner==n; non-owner ACK_O and ERR_O SHALL be 0.
REQ-018 Mn_DAT_O = S_DAT_I when owner==n, else 8'h00.
REQ-019 Watchdog counter (8 bit) SHALL increment each cycle S_STB_O=1 and S_ACK_I=0, clear on S_ACK_I=1, S_STB_O=0, or ownership change.
REQ-020 When counter reaches TIMEOUT: owner ERR_O=1 for exactly one cycle, S_STB_O forced 0 that cycle, counter cleared; grant retained.
REQ-021 S_ACK_I in the same cycle the counter reaches TIMEOUT SHALL win: ACK passed, no ERR.
REQ-022 S_ACK_I while IDLE SHALL be ignored (no ACK to any master).
REQ-023 Owner dropping CYC mid-transfer SHALL release immediately per REQ-013; a late S_ACK_I then routes only to the new owner rule (REQ-017).

Reset
REQ-024 RST_I=0 SHALL asynchronously force state IDLE, round-robin bit to 0, watchdog 0, O_grant 00.
REQ-025 During reset all outputs SHALL be 0 (S_*, Mn_ACK_O, Mn_ERR_O, Mn_DAT_O).
REQ-026 Reset mid-transfer SHALL abort without ACK/ERR; first grant after release follows REQ-012.

Structure
REQ-027 State encoding (IDLE/OWN0/OWN1) and default TIMEOUT SHALL live in shared package arbiter_pkg.
REQ-028 Watchdog SHALL be sub-module wb_watchdog (inputs: stb, ack, clear; output: expire pulse; parameter TIMEOUT).
REQ-029 Arbiter state machine and muxing SHALL stay in arbiter2_wb8; no other sub-modules.

Verification
REQ-030 M0 read alone at 0xFFFFF000, slave acks 1 cycle after STB with 8'hA5 -> O_grant=01 one cycle after CYC, M0_DAT_O=8'hA5 with M0_ACK_O, M1_ACK_O=0.
REQ-031 M0 and M1 raise CYC same cycle after reset -> OWN0 first; M0 drops CYC -> OWN1 next cycle with no IDLE; repeat contention -> OWN0 again after M1 release.
REQ-032 M1 write 8'h3C to 0xFFFFFF00 while M0 idle -> S_WE_O=1, S_DAT_O=8'h3C, S_ADR_O=0xFFFFFF00 during OWN1.
REQ-033 TIMEOUT=4, slave never acks -> M0_ERR_O pulses one cycle after 4 stalled cycles with S_STB_O=0 that cycle; ACK on exactly cycle 4 -> ACK, no ERR.
REQ-034 RST_I low mid-transfer in OWN1 -> all outputs 0 immediately (before next clock edge), O_grant=00; after release M0-only request -> OWN0.
REQ-035 S_ACK_I=1 while IDLE -> M0_ACK_O=M1_ACK_O=0.
